// File: rtl/fc_join_adder_skid.sv
// Joins two valid/ready operand streams, adds them at full width and holds the
// sums in a 2-entry skid buffer whose upstream ready comes only from a register.
module fc_join_adder_skid #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_vld,
  output logic         a_rdy,
  input  logic [w-1:0] a_data,
  input  logic         b_vld,
  output logic         b_rdy,
  input  logic [w-1:0] b_data,
  output logic         down_vld,
  input  logic         down_rdy,
  output logic [w:0]   down_data
);

  function automatic logic [w:0] add_wide(input logic [w-1:0] x, input logic [w-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  logic [1:0] r_count;
  logic [1:0] w_count_nxt;
  logic       r_full;
  logic [w:0] r_head;
  logic [w:0] r_tail;
  logic [w:0] w_sum;
  logic       w_in_ok;
  logic       w_push;
  logic       w_pop;

  // Ready looks only at the registered full flag, so down_rdy never reaches a_rdy/b_rdy.
  assign w_in_ok   = ~r_full;
  assign a_rdy     = w_in_ok & b_vld;
  assign b_rdy     = w_in_ok & a_vld;
  assign w_push    = a_vld & b_vld & w_in_ok;
  assign down_vld  = (r_count != 2'd0);
  assign w_pop     = down_vld & down_rdy;
  assign down_data = r_head;
  assign w_sum     = add_wide(a_data, b_data);

  always_comb begin
    w_count_nxt = r_count;
    case (r_count)
      2'd0: if (w_push) w_count_nxt = 2'd1;
      2'd1: begin
        if (w_push && !w_pop)      w_count_nxt = 2'd2;
        else if (!w_push && w_pop) w_count_nxt = 2'd0;
      end
      2'd2: if (w_pop) w_count_nxt = 2'd1;
      default: w_count_nxt = 2'd0;
    endcase
  end

  // Control state: occupancy and the registered full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == 2'd2);
    end
  end

  // Entry storage: head is always the oldest sum; tail only fills on a skid.
  always_ff @(posedge clk) begin
    case (r_count)
      2'd0: if (w_push) r_head <= w_sum;
      2'd1: begin
        if (w_push && w_pop) r_head <= w_sum;
        else if (w_push)     r_tail <= w_sum;
      end
      2'd2: if (w_pop) r_head <= r_tail;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fc_join_adder_skid.sv
// Bench for fc_join_adder_skid: directed vectors feed a scoreboard queue that a
// free-running monitor drains whenever the DUT hands a sum downstream.
module tb_fc_join_adder_skid;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_vld, b_vld, down_rdy;
  logic       a_rdy, b_rdy, down_vld;
  logic [7:0] a_data, b_data;
  logic [8:0] down_data;

  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       mon_stall;
  logic [8:0] mon_pd;

  fc_join_adder_skid #(.w(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_vld     (a_vld),
    .a_rdy     (a_rdy),
    .a_data    (a_data),
    .b_vld     (b_vld),
    .b_rdy     (b_rdy),
    .b_data    (b_data),
    .down_vld  (down_vld),
    .down_rdy  (down_rdy),
    .down_data (down_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops on every downstream transfer and checks hold-while-stalled.
  initial begin
    mon_stall = 1'b0;
    mon_pd    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_stall = 1'b0;
      end else begin
        if (mon_stall) begin
          chk("hold_vld", {31'd0, down_vld}, 32'd1);
          chk("hold_data", {23'd0, down_data}, {23'd0, mon_pd});
        end
        if (down_vld && down_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sum actual=%0d required=none", down_data);
          end else begin
            chk("sum", {23'd0, down_data}, {23'd0, exp_q.pop_front()});
          end
        end
        mon_stall = down_vld && !down_rdy;
        mon_pd    = down_data;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp,
                      input bit chk_vld);
    a_vld  = 1'b1;
    b_vld  = 1'b1;
    a_data = a;
    b_data = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (a_rdy && b_rdy) begin
        exp_q.push_back(exp);
        if (chk_vld) chk("no_bubble", {31'd0, down_vld}, 32'd1);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=no_handshake required=handshake a=%0d b=%0d", a, b);
  endtask

  task automatic idle();
    a_vld = 1'b0;
    b_vld = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  // Flip down_rdy mid-cycle; upstream ready must not move.
  task automatic comb_check();
    logic sa, sb;
    #2;
    sa = a_rdy;
    sb = b_rdy;
    down_rdy = ~down_rdy;
    #1;
    chk("comb_a_rdy", {31'd0, a_rdy}, {31'd0, sa});
    chk("comb_b_rdy", {31'd0, b_rdy}, {31'd0, sb});
    down_rdy = ~down_rdy;
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    a_vld    = 1'b0;
    b_vld    = 1'b0;
    a_data   = '0;
    b_data   = '0;
    down_rdy = 1'b1;
    #12;
    chk("reset_down_vld", {31'd0, down_vld}, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    b_vld = 1'b1;
    #1;
    chk("reset_a_rdy", {31'd0, a_rdy}, 32'd1);
    b_vld = 1'b0;
    @(posedge clk);
    #1;

    // 1: back-to-back 3+4 with 1-cycle latency and no bubbles
    for (int i = 0; i < 8; i++) send(8'd3, 8'd4, 9'd7, i > 0);
    idle();
    drain();

    // 2: width/carry corners
    send(8'd255, 8'd255, 9'd510, 1'b0);
    send(8'd0,   8'd0,   9'd0,   1'b0);
    send(8'd255, 8'd1,   9'd256, 1'b0);
    idle();
    drain();

    // 3: downstream stall; two sums held, then upstream blocked
    down_rdy = 1'b0;
    send(8'd1, 8'd1, 9'd2, 1'b0);
    send(8'd2, 8'd2, 9'd4, 1'b0);
    a_data = 8'd3;
    b_data = 8'd3;
    repeat (3) begin
      @(negedge clk);
      chk("full_a_rdy", {31'd0, a_rdy}, 32'd0);
      chk("full_b_rdy", {31'd0, b_rdy}, 32'd0);
    end
    @(posedge clk);
    comb_check();
    down_rdy = 1'b1;
    send(8'd3, 8'd3, 9'd6, 1'b0);
    send(8'd4, 8'd4, 9'd8, 1'b0);
    idle();
    drain();

    // 4: lone operand waits for its partner
    a_vld  = 1'b1;
    a_data = 8'd9;
    b_data = 8'd77;
    repeat (3) begin
      @(negedge clk);
      chk("lone_a_rdy", {31'd0, a_rdy}, 32'd0);
      chk("lone_no_push", {31'd0, down_vld}, 32'd0);
    end
    @(posedge clk);
    comb_check();
    send(8'd9, 8'd5, 9'd14, 1'b0);
    idle();
    drain();

    // 5: reset while two sums are buffered
    down_rdy = 1'b0;
    send(8'd10, 8'd20, 9'd30, 1'b0);
    send(8'd40, 8'd50, 9'd90, 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_down_vld", {31'd0, down_vld}, 32'd0);
    exp_q.delete();
    down_rdy = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    b_vld = 1'b1;
    #1;
    chk("post_rst_a_rdy", {31'd0, a_rdy}, 32'd1);
    b_vld = 1'b0;
    a_vld = 1'b1;
    #1;
    chk("post_rst_b_rdy", {31'd0, b_rdy}, 32'd1);
    chk("post_rst_down_vld", {31'd0, down_vld}, 32'd0);
    send(8'd100, 8'd27, 9'd127, 1'b0);
    idle();
    drain();

    // 6: random valid/ready traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      a_vld    = ($urandom_range(0, 3) != 0);
      b_vld    = ($urandom_range(0, 3) != 0);
      a_data   = 8'($urandom);
      b_data   = 8'($urandom);
      down_rdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (a_vld && a_rdy && b_vld && b_rdy)
        exp_q.push_back({1'b0, a_data} + {1'b0, b_data});
      @(posedge clk);
      #1;
    end
    down_rdy = 1'b1;
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
